// File: rtl/fma_align_sum_pipe.sv
// FMA align-and-sum stage: aligns addend Z against the product, then adds/subtracts; 2-cycle valid/ready pipe.
// Optional FMA_ALIGN_LZC_EN: when defined, stage 2 also registers the leading-zero count of sm.
module fma_align_sum_pipe #(
  parameter int NE  = 5,
  parameter int NF  = 10,
  parameter int W   = 3*NF+5,
  parameter int LZW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              xs,
  input  logic              ys,
  input  logic              zs,
  input  logic [NE+1:0]     pe,
  input  logic [NE-1:0]     ze,
  input  logic [NF-1:0]     zm,
  input  logic [2*NF+1:0]   pm,
  input  logic              x_zero,
  input  logic              y_zero,
  input  logic              z_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ss,
  output logic [NE+1:0]     se,
  output logic [W-1:0]      sm,
  output logic              sticky,
  output logic              zero_result,
  output logic [LZW-1:0]    lzc
);

  // Handshake
  logic s1_adv, s2_adv;

  // Stage 1 combinational alignment
  logic                 al_ps, al_inv, al_zsgn;
  logic signed [NE+2:0] acnt;
  logic signed [31:0]   acnt_ext;
  logic [W-1:0]         zvec, pvec;
  logic [2*W-1:0]       zsh;
  logic                 prod_hid;
  logic [W-1:0]         al_p, al_a;
  logic                 al_st;
  logic [NE+1:0]        al_se;

  // Stage 1 registers
  logic            s1_vld_q,  s1_vld_d;
  logic            s1_inv_q,  s1_inv_d;
  logic            s1_ps_q,   s1_ps_d;
  logic            s1_zs_q,   s1_zs_d;
  logic            s1_zsgn_q, s1_zsgn_d;
  logic [W-1:0]    s1_p_q,    s1_p_d;
  logic [W-1:0]    s1_a_q,    s1_a_d;
  logic            s1_st_q,   s1_st_d;
  logic [NE+1:0]   s1_se_q,   s1_se_d;

  // Stage 2 combinational sum
  logic [W:0]      sum;
  logic            sum_neg;
  logic [W-1:0]    sm_calc;
  logic            ss_calc;
  logic            zr_calc;
  logic [LZW-1:0]  lzc_calc;

  // Stage 2 (output) registers
  logic            out_vld_q, out_vld_d;
  logic            ss_q,      ss_d;
  logic [NE+1:0]   se_q,      se_d;
  logic [W-1:0]    sm_q,      sm_d;
  logic            sticky_q,  sticky_d;
  logic            zr_q,      zr_d;
  logic [LZW-1:0]  lzc_q,     lzc_d;

  always_comb begin
    s2_adv   = !out_vld_q || out_ready;
    s1_adv   = !s1_vld_q || s2_adv;
    in_ready = s1_adv;
  end

  // Alignment: Z starts with its 1.0 at the top bit and slides right by ACNT.
  always_comb begin
    al_ps    = xs ^ ys;
    al_inv   = al_ps ^ zs;
    al_zsgn  = xs & ys & zs;
    acnt     = $signed({pe[NE+1], pe}) - $signed({3'b000, ze}) + $signed((NE+3)'(NF+2));
    acnt_ext = 32'(acnt);
    zvec     = {(ze != '0), zm, {(W-NF-1){1'b0}}};
    pvec     = {{(W-2*NF-4){1'b0}}, pm, 2'b00};
    zsh      = {zvec, {W{1'b0}}} >> acnt[NE+2:0];
    prod_hid = x_zero | y_zero | acnt[NE+2];
    if (prod_hid) begin
      al_p  = '0;
      al_a  = zvec;
      al_st = !(x_zero | y_zero);
      al_se = {2'b00, ze};
    end else if (acnt_ext >= W) begin
      al_p  = pvec;
      al_a  = '0;
      al_st = !z_zero;
      al_se = pe;
    end else begin
      al_p  = pvec;
      al_a  = zsh[2*W-1:W];
      al_st = |zsh[W-1:0];
      al_se = pe;
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_inv_d  = s1_inv_q;
    s1_ps_d   = s1_ps_q;
    s1_zs_d   = s1_zs_q;
    s1_zsgn_d = s1_zsgn_q;
    s1_p_d    = s1_p_q;
    s1_a_d    = s1_a_q;
    s1_st_d   = s1_st_q;
    s1_se_d   = s1_se_q;
    if (s1_adv) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_inv_d  = al_inv;
        s1_ps_d   = al_ps;
        s1_zs_d   = zs;
        s1_zsgn_d = al_zsgn;
        s1_p_d    = al_p;
        s1_a_d    = al_a;
        s1_st_d   = al_st;
        s1_se_d   = al_se;
      end
    end
  end

  // Subtraction uses the one's complement plus !sticky: a nonzero tail lost
  // from A means the true difference lies just below P-A, so we floor.
  always_comb begin
    if (s1_inv_q) begin
      sum = {1'b0, s1_p_q} + ~{1'b0, s1_a_q} + (W+1)'(!s1_st_q);
    end else begin
      sum = {1'b0, s1_p_q} + {1'b0, s1_a_q};
    end
    sum_neg = s1_inv_q & sum[W];
    sm_calc = sum_neg ? (~sum[W-1:0] + W'(1)) : sum[W-1:0];
    ss_calc = sum_neg ? s1_zs_q : s1_ps_q;
    zr_calc = (sm_calc == '0) && !s1_st_q;
    if (zr_calc) begin
      ss_calc = s1_inv_q ? 1'b0 : s1_zsgn_q;
    end
  end

`ifdef FMA_ALIGN_LZC_EN
  always_comb begin
    lzc_calc = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (sm_calc[i]) lzc_calc = LZW'(W-1-i);
    end
  end
`else
  always_comb begin
    lzc_calc = '0;
  end
`endif

  always_comb begin
    out_vld_d = out_vld_q;
    ss_d      = ss_q;
    se_d      = se_q;
    sm_d      = sm_q;
    sticky_d  = sticky_q;
    zr_d      = zr_q;
    lzc_d     = lzc_q;
    if (s2_adv) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        ss_d     = ss_calc;
        se_d     = s1_se_q;
        sm_d     = sm_calc;
        sticky_d = s1_st_q;
        zr_d     = zr_calc;
        lzc_d    = lzc_calc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_inv_q  <= 1'b0;
      s1_ps_q   <= 1'b0;
      s1_zs_q   <= 1'b0;
      s1_zsgn_q <= 1'b0;
      s1_p_q    <= '0;
      s1_a_q    <= '0;
      s1_st_q   <= 1'b0;
      s1_se_q   <= '0;
      out_vld_q <= 1'b0;
      ss_q      <= 1'b0;
      se_q      <= '0;
      sm_q      <= '0;
      sticky_q  <= 1'b0;
      zr_q      <= 1'b0;
      lzc_q     <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_inv_q  <= s1_inv_d;
      s1_ps_q   <= s1_ps_d;
      s1_zs_q   <= s1_zs_d;
      s1_zsgn_q <= s1_zsgn_d;
      s1_p_q    <= s1_p_d;
      s1_a_q    <= s1_a_d;
      s1_st_q   <= s1_st_d;
      s1_se_q   <= s1_se_d;
      out_vld_q <= out_vld_d;
      ss_q      <= ss_d;
      se_q      <= se_d;
      sm_q      <= sm_d;
      sticky_q  <= sticky_d;
      zr_q      <= zr_d;
      lzc_q     <= lzc_d;
    end
  end

  always_comb begin
    out_valid   = out_vld_q;
    ss          = ss_q;
    se          = se_q;
    sm          = sm_q;
    sticky      = sticky_q;
    zero_result = zr_q;
    lzc         = lzc_q;
  end

endmodule

// File: tb/tb_fma_align_sum_pipe.sv
// Scoreboard bench for fma_align_sum_pipe (half-precision parameters), directed vectors.
module tb_fma_align_sum_pipe;
  localparam int NE = 5, NF = 10, W = 35, LZW = 6;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic xs = 0, ys = 0, zs = 0, x_zero = 0, y_zero = 0, z_zero = 0;
  logic [NE+1:0] pe = '0;
  logic [NE-1:0] ze = '0;
  logic [NF-1:0] zm = '0;
  logic [2*NF+1:0] pm = '0;
  logic ss, sticky, zero_result;
  logic [NE+1:0] se;
  logic [W-1:0] sm;
  logic [LZW-1:0] lzc;

  typedef struct packed {
    logic [W-1:0]   sm;
    logic           ss;
    logic [NE+1:0]  se;
    logic           st;
    logic           zr;
    logic [LZW-1:0] lz;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0, n_pushed = 0, n_seen = 0;

  always #5 clk = ~clk;

  fma_align_sum_pipe #(.NE(NE), .NF(NF), .W(W), .LZW(LZW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .xs(xs), .ys(ys), .zs(zs), .pe(pe), .ze(ze), .zm(zm), .pm(pm),
    .x_zero(x_zero), .y_zero(y_zero), .z_zero(z_zero),
    .out_valid(out_valid), .out_ready(out_ready), .ss(ss), .se(se), .sm(sm),
    .sticky(sticky), .zero_result(zero_result), .lzc(lzc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] e_sm, input logic e_ss, input logic [NE+1:0] e_se,
                              input logic e_st, input logic e_zr, input logic [LZW-1:0] e_lz);
    exp_t e;
    e.sm = e_sm; e.ss = e_ss; e.se = e_se; e.st = e_st; e.zr = e_zr;
`ifdef FMA_ALIGN_LZC_EN
    e.lz = e_lz;
`else
    e.lz = (e_lz == e_lz) ? '0 : '1;
`endif
    return e;
  endfunction

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        check("beat", 64'({sm, ss, se, sticky, zero_result, lzc}), 64'(mon_e));
        n_seen++;
      end
    end
  end

  task automatic send(input logic [NE+1:0] v_pe, input logic [NE-1:0] v_ze, input logic [NF-1:0] v_zm,
                      input logic v_xs, input logic v_ys, input logic v_zs,
                      input logic v_xz, input logic v_yz, input logic v_zz,
                      input exp_t e, input bit push);
    int waited = 0;
    pe = v_pe; ze = v_ze; zm = v_zm; pm = 22'h100000;
    xs = v_xs; ys = v_ys; zs = v_zs; x_zero = v_xz; y_zero = v_yz; z_zero = v_zz;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else if (push) begin
      q.push_back(e);
      n_pushed++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", 64'({sm, ss, se, sticky, zero_result, lzc}), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // pe, ze, zm, xs, ys, zs, xz, yz, zz
    send(15, 15, 0,     0,0,0, 0,0,0, mk(35'h800000,    0, 15, 0, 0, 11), 1); // 1+1
    send(15, 15, 0,     0,0,1, 0,0,0, mk(35'h0,         0, 15, 0, 1, 35), 1); // 1-1
    send(15, 2,  0,     0,0,0, 0,0,0, mk(35'h400200,    0, 15, 0, 0, 12), 1); // small addend
    send(30, 1,  0,     0,0,0, 0,0,0, mk(35'h400000,    0, 30, 1, 0, 12), 1); // Z invisible
    send(30, 1,  0,     0,0,1, 0,0,0, mk(35'h3FFFFF,    0, 30, 1, 0, 13), 1); // Z invisible, subtract
    send(15, 16, 0,     0,0,1, 0,0,0, mk(35'h400000,    1, 15, 0, 0, 12), 1); // negative difference
    send(15, 15, 10'h155, 0,0,0, 1,0,0, mk(35'h555000000, 0, 15, 0, 0, 0), 1); // product zero
    send(2,  20, 0,     0,0,0, 0,0,0, mk(35'h400000000, 0, 20, 1, 0, 0), 1); // ACNT<0
    send(15, 1,  10'h3FF, 0,0,0, 0,0,0, mk(35'h4001FF,  0, 15, 1, 0, 12), 1); // shifted-out sticky
    send(15, 0,  10'h200, 0,0,0, 0,0,0, mk(35'h400040,  0, 15, 0, 0, 12), 1); // subnormal Z
    send(15, 0,  0,     1,0,1, 1,0,1, mk(35'h0,         0, 0,  0, 1, 35), 1); // exact zero, no inv
    drain();

    // Backpressure: two beats fill the pipe, the third must wait.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(15, 15, 0, 0,0,0, 0,0,0, mk(35'h800000, 0, 15, 0, 0, 11), 1);
    send(15, 2,  0, 0,0,0, 0,0,0, mk(35'h400200, 0, 15, 0, 0, 12), 1);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    check("bp_sm_held", 64'(sm), 64'h800000);
    fork
      send(30, 1, 0, 0,0,0, 0,0,0, mk(35'h400000, 0, 30, 1, 0, 12), 1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight: in-flight beats are never pushed and must never appear.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(15, 15, 0, 0,0,0, 0,0,0, mk(35'h800000, 0, 15, 0, 0, 11), 0);
    send(15, 2,  0, 0,0,0, 0,0,0, mk(35'h400200, 0, 15, 0, 0, 12), 0);
    @(negedge clk);
    check("full_before_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("beats_seen", 64'(n_seen), 64'(n_pushed));
    check("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
